instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Parametrised instruction fetch unit between the program memory port and the decode stage. It holds the program counter and issues word-addressed read requests over a valid/ready request channel. It accepts read responses, buffers instructions with their PCs in a small FIFO, and presents them to decode over a valid/ready handshake. It supports PC redirect (branch/jump) with flush and discard of stale in-flight responses.

Parameters:
ADDR_W, 8, program counter / memory address width in bits
INSTR_W, 16, instruction word width in bits
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2)
PC_RESET, 0, PC value loaded at reset (ADDR_W bits)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
enable  input  1  permits issue of new fetch requests
pc_load  input  1  redirect strobe, one cycle
pc_load_addr  input  ADDR_W  redirect target
mem_req_valid  output  1  read request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  ADDR_W  read address
mem_resp_valid  input  1  read data valid, one cycle per accepted request
mem_resp_data  input  INSTR_W  read data
instr_valid  output  1  buffered instruction available
instr_ready  input  1  decode accepts instruction
instr_data  output  INSTR_W  instruction at FIFO head
instr_pc  output  ADDR_W  PC of instr_data
busy  output  1  request pending or outstanding

Behaviour:
- Reset (async, clk domain), all regs: pc=PC_RESET, state=IDLE, FIFO empty, stale=0. Outputs mem_req_valid=0, mem_req_addr=PC_RESET, instr_valid=0, instr_data=0, instr_pc=0, busy=0. Reset mid-transaction drops everything; a late mem_resp_valid after reset in IDLE is ignored.
- At most one request outstanding. States:
  - IDLE: issue when enable && count<FIFO_DEPTH && !pc_load. Next state REQ. mem_req_valid=1 and mem_req_addr=pc from the next cycle.
  - REQ: mem_req_valid=1. Address is held stable until accepted. On mem_req_valid&&mem_req_ready: pc<=pc+1 (wraps modulo 2^ADDR_W), go to WAIT.
  - WAIT: wait for mem_resp_valid. If stale=0, push {pc_of_request, mem_resp_data}. If stale=1, discard and clear stale. Go to IDLE. Response in the same cycle as acceptance is not legal (memory latency >=1).
- Issue condition counts the outstanding slot. Since IDLE requires count<FIFO_DEPTH and only one request is in flight, a push never overflows.
- FIFO: instr_valid=!empty. Head drives instr_data/instr_pc. Pop on instr_valid&&instr_ready. Simultaneous push+pop keeps count unchanged. Pointers wrap modulo FIFO_DEPTH.
- pc_load (priority over everything except reset):
  - pc<=pc_load_addr.
  - FIFO flushed, including any same-cycle push or pop, so instr_valid=0 next cycle.
  - REQ or WAIT: stale<=1; the in-flight or pending request completes its handshake normally (valid not withdrawn), and its response is dropped.
  - WAIT with mem_resp_valid in the same cycle: that response is dropped, stale stays 0, go to IDLE.
  - IDLE: no issue that cycle.
  - Fetching restarts from pc_load_addr after the stale response clears.
- pc_load in REQ with same-cycle acceptance: pc<=pc_load_addr (not +1), state WAIT, stale=1.
- enable=0: no new issue from IDLE. A pending REQ/WAIT completes and its response is buffered. The FIFO keeps draining.
- busy=1 in REQ or WAIT, else 0.
- Steady-state throughput: one instruction per 3 cycles at 1-cycle memory latency.

Test Plan:
- Reset then enable=1, ready mem (req_ready=1, resp 1 cycle later, data=addr+16'hA000), instr_ready=1 -> instr_pc 0,1,2,3 with instr_data A000,A001,A002,A003 in order; no gaps beyond 3-cycle cadence.
- instr_ready=0, FIFO_DEPTH=2 -> exactly 2 requests issued (addr 0,1), then mem_req_valid stays 0. Assert instr_ready -> fetch resumes at addr 2.
- mem_req_ready held 0 for 5 cycles -> mem_req_valid=1 and mem_req_addr constant for all 5 cycles; accepted on cycle 6.
- pc_load=1, pc_load_addr=8'h40 while in WAIT for addr 5 -> addr-5 response discarded, FIFO empty next cycle, next request addr 8'h40, first instr_pc=8'h40.
- pc at 8'hFF, fetch continues -> request addrs FF then 00; instr_pc wraps the same way.
- Assert reset during WAIT, then deliver mem_resp_valid -> response ignored, instr_valid=0, pc=PC_RESET, first post-reset request addr=PC_RESET.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Instruction fetch stage sitting between the program memory port and decode.
// Holds the program counter and issues one word-addressed read at a time. It
// buffers each returned instruction with its PC in a small FIFO and hands them
// to decode over a valid/ready handshake. A redirect (pc_load) flushes the
// buffer and marks any request already on the bus as stale so its response is
// thrown away.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   enable                     allow new fetch requests to be issued
//   pc_load, pc_load_addr      one-cycle redirect strobe and target PC
//   mem_req_valid/ready/addr   read request channel to program memory
//   mem_resp_valid/data        read response, one per accepted request
//   instr_valid/ready          instruction handshake towards decode
//   instr_data, instr_pc       instruction at the FIFO head and its PC
//   busy                       a request is pending or outstanding
module instr_fetch_unit #(
  parameter int                 ADDR_W     = 8,
  parameter int                 INSTR_W    = 16,
  parameter int                 FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0]  PC_RESET   = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               pc_load,
  input  logic [ADDR_W-1:0]  pc_load_addr,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDR_W-1:0]  mem_req_addr,
  input  logic               mem_resp_valid,
  input  logic [INSTR_W-1:0] mem_resp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  req_addr;
  logic               stale;

  logic [INSTR_W-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0]  fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  logic issue;
  logic accept;
  logic resp;
  logic push;
  logic pop;

  // Only one request is ever in flight, so count < FIFO_DEPTH in IDLE already
  // reserves a slot for the response and the push can never overflow.
  assign issue  = (state == IDLE) && enable && (count < CNT_W'(FIFO_DEPTH)) && !pc_load;
  assign accept = (state == REQ) && mem_req_ready;
  assign resp   = (state == WAIT) && mem_resp_valid;
  // A response is dropped if it belongs to a pre-redirect request or if the
  // redirect arrives in the very same cycle.
  assign push   = resp && !stale && !pc_load;
  assign pop    = instr_valid && instr_ready;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (issue)          state_next = REQ;
      REQ:     if (accept)         state_next = WAIT;
      WAIT:    if (mem_resp_valid) state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The request address is latched at issue so it stays stable on the bus
  // even if a redirect changes pc while the request is still pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= PC_RESET;
      req_addr <= PC_RESET;
      stale    <= 1'b0;
    end else begin
      if (issue)
        req_addr <= pc;
      if (pc_load)
        pc <= pc_load_addr;
      else if (accept)
        pc <= pc + ADDR_W'(1);
      if (resp)
        stale <= 1'b0;
      else if (pc_load && (state != IDLE))
        stale <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (pc_load) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: it is only visible through the head while the
  // FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_resp_data;
      fifo_pc[wr_ptr]   <= req_addr;
    end
  end

  assign mem_req_valid = (state == REQ);
  assign mem_req_addr  = req_addr;
  assign busy          = (state != IDLE);
  assign instr_valid   = (count != '0);
  assign instr_data    = instr_valid ? fifo_data[rd_ptr] : '0;
  assign instr_pc      = instr_valid ? fifo_pc[rd_ptr]   : '0;

endmodule
